// File: rtl/timing_decoder.sv
// T-state ring, registered opcode decode, run/step gating and halt latch.
// Ports: clk, reset_n, ir, reset_timer, finish_signal, run, step_req, resume -> timer, IR_dicode, halted, wrap_err, instr_count.
module timing_decoder #(
  parameter int T_STATES = 8,
  parameter int IR_WIDTH = 8,
  parameter int OPC_LSB  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                reset_timer,
  input  logic                finish_signal,
  input  logic                run,
  input  logic                step_req,
  input  logic                resume,
  output logic [T_STATES-1:0] timer,
  output logic [15:0]         IR_dicode,
  output logic                halted,
  output logic                wrap_err,
  output logic [15:0]         instr_count
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [T_STATES-1:0] T0 = T_STATES'(1);

  state_t              state_q, state_d;
  logic [T_STATES-1:0] timer_d;
  logic [15:0]         dicode_d;
  logic [15:0]         cnt_d;
  logic                wrap_d;
  logic                step_q;
  logic                fin_q;
  logic                step_pulse;
  logic                fin_rise;
  logic                adv;
  logic [3:0]          opc;
  logic                unused_ir;

  assign step_pulse = step_req & ~step_q;
  assign fin_rise   = finish_signal & ~fin_q;
  assign adv        = run | step_pulse;
  assign opc        = ir[OPC_LSB+3:OPC_LSB];
  assign unused_ir  = ^ir;
  assign halted     = (state_q == S_HALTED);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer;
    dicode_d = IR_dicode;
    wrap_d   = wrap_err;
    cnt_d    = instr_count;
    unique case (state_q)
      S_RUN: begin
        if (fin_rise) begin
          state_d  = S_HALTED;
          timer_d  = '0;
          dicode_d = '0;
          cnt_d    = instr_count + 16'd1;
        end else if (reset_timer) begin
          timer_d  = T0;
          dicode_d = '0;
          cnt_d    = instr_count + 16'd1;
        end else if (adv) begin
          if (timer[T_STATES-1]) begin
            timer_d  = T0;
            dicode_d = '0;
            wrap_d   = 1'b1;
          end else begin
            timer_d = timer << 1;
            // Opcode is latched on the T2->T3 edge only.
            if (timer[2])
              dicode_d = 16'd1 << opc;
          end
        end
      end
      S_HALTED: begin
        timer_d  = '0;
        dicode_d = '0;
        if (resume) begin
          state_d = S_RUN;
          timer_d = T0;
        end
      end
      default: begin
        state_d  = S_RUN;
        timer_d  = T0;
        dicode_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      timer       <= T0;
      IR_dicode   <= '0;
      wrap_err    <= 1'b0;
      instr_count <= '0;
      step_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer       <= timer_d;
      IR_dicode   <= dicode_d;
      wrap_err    <= wrap_d;
      instr_count <= cnt_d;
      step_q      <= step_req;
      fin_q       <= finish_signal;
    end
  end

endmodule

// File: tb/tb_timing_decoder.sv
// Directed bench for timing_decoder.
// Walks fetch/decode, wrap, single-step, halt/resume, async reset, counter wrap.
module tb_timing_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ir;
  logic        reset_timer;
  logic        finish_signal;
  logic        run;
  logic        step_req;
  logic        resume;
  logic [7:0]  timer;
  logic [15:0] IR_dicode;
  logic        halted;
  logic        wrap_err;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  timing_decoder #(
    .T_STATES(8),
    .IR_WIDTH(8),
    .OPC_LSB (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir           (ir),
    .reset_timer  (reset_timer),
    .finish_signal(finish_signal),
    .run          (run),
    .step_req     (step_req),
    .resume       (resume),
    .timer        (timer),
    .IR_dicode    (IR_dicode),
    .halted       (halted),
    .wrap_err     (wrap_err),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    ir            = 8'h00;
    reset_timer   = 1'b0;
    finish_signal = 1'b0;
    run           = 1'b0;
    step_req      = 1'b0;
    resume        = 1'b0;
    #12;
    chk("rst_timer", timer, 32'h01);
    chk("rst_dicode", IR_dicode, 32'h0);
    chk("rst_halted", halted, 32'h0);
    chk("rst_wrap", wrap_err, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    tick();
    reset_n = 1'b1;

    // LDA: fetch, decode at T3, end with reset_timer in T5
    run = 1'b1;
    ir  = 8'h0A;
    tick(); chk("lda_t1", timer, 32'h02);
    tick(); chk("lda_t2", timer, 32'h04);
    chk("lda_t2_dic", IR_dicode, 32'h0);
    tick(); chk("lda_t3", timer, 32'h08);
    chk("lda_t3_dic", IR_dicode, 32'h0001);
    tick(); tick();
    chk("lda_t5", timer, 32'h20);
    reset_timer = 1'b1;
    tick();
    reset_timer = 1'b0;
    chk("lda_end_timer", timer, 32'h01);
    chk("lda_end_dic", IR_dicode, 32'h0);
    chk("lda_end_cnt", instr_count, 32'd1);

    // JMP without reset_timer: ring wraps and flags it
    ir = 8'hE3;
    tick(); tick(); tick();
    chk("jmp_t3_dic", IR_dicode, 32'h4000);
    tick(); tick(); tick(); tick();
    chk("jmp_t7", timer, 32'h80);
    chk("jmp_t7_wrap", wrap_err, 32'h0);
    tick();
    run = 1'b0;
    chk("wrap_timer", timer, 32'h01);
    chk("wrap_flag", wrap_err, 32'h1);
    chk("wrap_dic", IR_dicode, 32'h0);
    tick(); tick();
    chk("wrap_hold_timer", timer, 32'h01);
    chk("wrap_sticky", wrap_err, 32'h1);
    chk("wrap_cnt", instr_count, 32'd1);

    // single step: held request gives exactly one advance
    step_req = 1'b1;
    repeat (5) tick();
    chk("step_hold", timer, 32'h02);
    step_req = 1'b0;
    tick();
    ir = 8'h62;
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("step_p1", timer, 32'h04);
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("step_p2", timer, 32'h08);
    chk("step_dic", IR_dicode, 32'h0040);
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("step_p3", timer, 32'h10);
    chk("step_dic_hold", IR_dicode, 32'h0040);
    // reset_timer is honoured even with no advance
    reset_timer = 1'b1;
    tick();
    reset_timer = 1'b0;
    chk("rt_noadv_timer", timer, 32'h01);
    chk("rt_noadv_cnt", instr_count, 32'd2);

    // HLT, idle, ignored inputs, resume
    ir  = 8'hF0;
    run = 1'b1;
    tick(); tick(); tick();
    chk("hlt_t3", timer, 32'h08);
    chk("hlt_dic", IR_dicode, 32'h8000);
    finish_signal = 1'b1;
    tick();
    chk("halt_flag", halted, 32'h1);
    chk("halt_timer", timer, 32'h00);
    chk("halt_dic", IR_dicode, 32'h0);
    chk("halt_cnt", instr_count, 32'd3);
    reset_timer = 1'b1;
    step_req    = 1'b1;
    repeat (10) tick();
    reset_timer = 1'b0;
    step_req    = 1'b0;
    chk("idle_flag", halted, 32'h1);
    chk("idle_timer", timer, 32'h00);
    chk("idle_cnt", instr_count, 32'd3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_timer", timer, 32'h01);
    chk("resume_flag", halted, 32'h0);
    tick(); tick(); tick();
    chk("no_rehalt", halted, 32'h0);
    chk("no_rehalt_timer", timer, 32'h08);
    tick();
    chk("pre_rst_t4", timer, 32'h10);
    chk("pre_rst_dic", IR_dicode, 32'h8000);

    // async reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_timer", timer, 32'h01);
    chk("arst_dic", IR_dicode, 32'h0);
    chk("arst_cnt", instr_count, 32'h0);
    chk("arst_wrap", wrap_err, 32'h0);
    finish_signal = 1'b0;
    run           = 1'b0;
    tick();
    reset_n = 1'b1;

    // counter wrap
    reset_timer = 1'b1;
    repeat (65535) tick();
    chk("cnt_max", instr_count, 32'hFFFF);
    tick();
    reset_timer = 1'b0;
    chk("cnt_wrap", instr_count, 32'h0000);
    chk("cnt_wrap_timer", timer, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
